// File: rtl/i_tree_pkg.sv
// Shared constants and types for the isolation-tree detector
// and its alarm back-end.
package i_tree_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    MONITOR = 2'd0,
    ALARM   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int DEF_WINDOW    = 1024;
  localparam int DEF_THRESHOLD = 4;
  localparam int DEF_HOLDOFF   = 256;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_TOTAL_W   = 16;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/anomaly_alarm_manager_if.sv
// Detector-to-host bundle for the alarm manager:
// anomaly flag and ack in, alarm status out.
interface anomaly_alarm_manager_if
  import i_tree_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_W,
  parameter int TOTAL_WIDTH = DEF_TOTAL_W
);

  logic                   anomaly_detected;
  logic                   alarm_ack;
  logic                   alarm;
  logic [CNT_WIDTH-1:0]   alarm_event_count;
  logic [TOTAL_WIDTH-1:0] total_events;
  logic                   window_tick;
  logic [STATE_W-1:0]     state;

  modport master (
    output anomaly_detected,
    output alarm_ack,
    input  alarm,
    input  alarm_event_count,
    input  total_events,
    input  window_tick,
    input  state
  );

  modport slave (
    input  anomaly_detected,
    input  alarm_ack,
    output alarm,
    output alarm_event_count,
    output total_events,
    output window_tick,
    output state
  );

endinterface

// File: rtl/anomaly_alarm_manager_sat_counter.sv
// Saturating up-counter with synchronous clear;
// clear wins over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/anomaly_alarm_manager.sv
// Debounced, acknowledged alarm built from windowed
// anomaly event counts.
module anomaly_alarm_manager
  import i_tree_pkg::*;
#(
  parameter int WINDOW_CYCLES  = DEF_WINDOW,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF,
  parameter int CNT_WIDTH      = DEF_CNT_W,
  parameter int TOTAL_WIDTH    = DEF_TOTAL_W
) (
  input  logic clk,
  input  logic reset,
  anomaly_alarm_manager_if.slave bus
);

  localparam int WT_W = clog2_min1(WINDOW_CYCLES);
  localparam int HO_W = clog2_min1(HOLDOFF_CYCLES);

  localparam logic [WT_W-1:0] WIN_LAST =
    WT_W'(WINDOW_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LOAD =
    HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] THR =
    CNT_WIDTH'(THRESHOLD);

  state_t                 state_q;
  state_t                 state_d;
  logic                   anom_q;
  logic                   evt;
  logic                   tick;
  logic                   trig;
  logic                   win_clr;
  logic                   win_inc;
  logic                   alarm_q;
  logic [WT_W-1:0]        win_timer;
  logic [HO_W-1:0]        ho_timer;
  logic [CNT_WIDTH-1:0]   win_count;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [CNT_WIDTH-1:0]   aec_q;
  logic [TOTAL_WIDTH-1:0] total;

  assign evt  = bus.anomaly_detected & ~anom_q;
  assign tick = (state_q == MONITOR) &&
                (win_timer == WIN_LAST);

  // Count as it would be after this cycle, so an event on
  // the tick cycle still belongs to the closing window.
  assign cnt_next = (win_count == '1) ? win_count
                  : win_count + CNT_WIDTH'(evt);
  assign trig = (state_q == MONITOR) && (cnt_next >= THR);

  assign win_inc = evt && (state_q == MONITOR);
  assign win_clr = tick ||
                   ((state_q != MONITOR) &&
                    (state_q != ALARM));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MONITOR: if (trig) state_d = ALARM;
      ALARM:   if (bus.alarm_ack) state_d = HOLDOFF;
      HOLDOFF: if (ho_timer == '0) state_d = MONITOR;
      default: state_d = MONITOR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MONITOR;
      anom_q    <= 1'b0;
      alarm_q   <= 1'b0;
      aec_q     <= '0;
      win_timer <= '0;
      ho_timer  <= '0;
    end else begin
      state_q <= state_d;
      anom_q  <= bus.anomaly_detected;
      alarm_q <= (state_d == ALARM);
      if (trig) aec_q <= cnt_next;

      if (state_q == MONITOR) begin
        win_timer <= tick ? '0 : win_timer + WT_W'(1);
      end else if (state_q != ALARM) begin
        win_timer <= '0;
      end

      if ((state_q == ALARM) && bus.alarm_ack) begin
        ho_timer <= HO_LOAD;
      end else if ((state_q == HOLDOFF) &&
                   (ho_timer != '0)) begin
        ho_timer <= ho_timer - HO_W'(1);
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_win_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (win_clr),
    .inc   (win_inc),
    .count (win_count)
  );

  sat_counter #(
    .WIDTH (TOTAL_WIDTH)
  ) u_total_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (evt),
    .count (total)
  );

  assign bus.alarm             = alarm_q;
  assign bus.alarm_event_count = aec_q;
  assign bus.total_events      = total;
  assign bus.window_tick       = tick;
  assign bus.state             = state_q;

endmodule

// File: doc/anomaly_alarm_manager.md
Name: anomaly_alarm_manager

Overview:
- Downstream stage of the isolation-tree detector. Consumes its anomaly_detected output and turns raw per-sample anomaly flags into a debounced, acknowledged alarm.
- Counts anomaly events in fixed (tumbling) windows of WINDOW_CYCLES clocks.
- Raises alarm when the in-window count reaches THRESHOLD, holds it until acknowledged, then enforces a hold-off before monitoring resumes.

Parameters:
WINDOW_CYCLES, 1024, length of one counting window in clock cycles (legal range >= 2)
THRESHOLD, 4, in-window event count that triggers alarm (legal range 1 .. 2^CNT_WIDTH-1)
HOLDOFF_CYCLES, 256, cycles spent in HOLDOFF after acknowledge (legal range >= 1)
CNT_WIDTH, 8, width of the in-window event counter
TOTAL_WIDTH, 16, width of the lifetime event counter

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
anomaly_detected  input  1  anomaly flag from the detector (level)
alarm_ack  input  1  host acknowledge; sampled only in ALARM
alarm  output  1  alarm active
alarm_event_count  output  CNT_WIDTH  in-window count captured at trigger
total_events  output  TOTAL_WIDTH  lifetime event count, saturating
window_tick  output  1  one-cycle pulse on the last cycle of each window
state  output  2  current FSM state, for debug

Behaviour:
- Reset (synchronous, active-high, at clk edge): all outputs are 0, anom_q=0, timers=0, win_count=0, state=MONITOR. Reset mid-alarm or mid-holdoff aborts immediately with no residual state.
- Event definition: evt = anomaly_detected & ~anom_q. anom_q is anomaly_detected registered.
  - A level held high counts exactly once.
  - A new event requires a low cycle first.
- Lifetime counter: total_events increments on every evt in every state and saturates at all-ones.
- State encoding: MONITOR=0, ALARM=1, HOLDOFF=2. Encoding 3 is unreachable and recovers to MONITOR.
- MONITOR:
  - win_timer counts 0..WINDOW_CYCLES-1. window_tick is combinational, high when win_timer==WINDOW_CYCLES-1.
  - On that cycle, win_timer wraps to 0 and win_count clears to 0.
  - An evt on the tick cycle belongs to the closing window: it is included in the threshold check and is not carried over.
  - win_count increments on evt and saturates at 2^CNT_WIDTH-1.
  - If win_count+evt >= THRESHOLD in a cycle:
    - next state is ALARM;
    - alarm_event_count is loaded with the saturated win_count+evt;
    - alarm goes to 1 at that edge.
  - Latency: anomaly_detected rises in cycle t -> evt in t -> alarm high from cycle t+1 when the threshold is reached.
  - alarm_ack is ignored in MONITOR.
- ALARM:
  - alarm=1. win_timer and win_count are frozen. window_tick stays low.
  - When alarm_ack=1 is sampled: next state is HOLDOFF, alarm=0 from the next cycle, holdoff timer is loaded with HOLDOFF_CYCLES-1.
  - A held-high ack causes no further effect.
- HOLDOFF:
  - Timer decrements each cycle. evt affects only total_events.
  - When the timer is 0: next state is MONITOR with win_timer=0 and win_count=0, so a fresh window starts.
  - HOLDOFF lasts exactly HOLDOFF_CYCLES cycles.
  - alarm_ack is ignored.
- Simultaneous events:
  - Trigger and ack in the same MONITOR cycle: ack is ignored and the alarm is still raised.
  - Tick and trigger in the same cycle: tick pulses, window resets, and ALARM is entered.
- alarm_event_count holds its value until the next trigger or reset.
- All outputs are registered except window_tick and state, which are decoded from registers.

Decomposition:
- Shared package/include i_tree_pkg:
  - state localparams MONITOR/ALARM/HOLDOFF;
  - 2-bit state width constant;
  - default WINDOW/THRESHOLD/HOLDOFF constants, reused by the top-level i_tree.
- One sub-module: sat_counter (parameter WIDTH; inputs clk, reset, clear, inc; output count).
  - clear has priority over inc.
  - Instantiated for win_count and total_events.
- The FSM, edge detect and timers stay in anomaly_alarm_manager.

Test Plan:
Bench parameters throughout: WINDOW_CYCLES=16, THRESHOLD=3, HOLDOFF_CYCLES=4, CNT_WIDTH=4, TOTAL_WIDTH=4.
1. Three 1-cycle anomaly pulses at window cycles 2, 5, 8 -> alarm rises the cycle after cycle 8, alarm_event_count=3, total_events=3, state=1.
2. anomaly_detected held high 10 cycles -> exactly one event, total_events=1, no alarm; window_tick pulses every 16 cycles.
3. Two pulses in window N, one pulse on cycle 0 of window N+1, the third pulse landing on window N's tick cycle -> alarm triggered by window N (count 3); in the alternate run with the third pulse one cycle later, no alarm.
4. In ALARM, ack high for 1 cycle -> alarm low the next cycle, state=2 for exactly 4 cycles, then state=0; pulses during ALARM/HOLDOFF raise total_events only, and the new window starts at count 0.
5. 20 spaced pulses across windows with repeated acks -> total_events saturates at 15.
6. Assert reset mid-ALARM and mid-HOLDOFF -> next cycle all outputs 0, state=0; ack at the same edge as the trigger cycle is ignored (alarm stays high).
